muldiv_hilo: RTL
================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal values are even and >= 4.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only while busy=0.
REQ-005 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 a  input  WIDTH  multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  input  WIDTH  multiplier or divisor.
REQ-008 abort  input  1  cancels the in-flight operation.
REQ-009 busy  output  1  high while an operation is in flight; the pipeline uses it as its stall.
REQ-010 done  output  1  one-cycle pulse when HI/LO are written by a MULT/MULTU/DIV/DIVU.
REQ-011 dbz  output  1  sticky flag: the last completed divide had b=0.
REQ-012 hi  output  WIDTH  HI register.
REQ-013 lo  output  WIDTH  LO register.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX; busy=1 exactly in CALC and FIX.
REQ-015 IDLE with start=1 and op in {000..011} SHALL latch a, b and op, load the iteration counter with WIDTH, and enter CALC at the next edge.
REQ-016 IDLE with start=1 and op=100 (or 101) SHALL write a into hi (or lo) at that edge, stay in IDLE, and keep busy=0 and done=0.
REQ-017 start with op 11x, and start while busy=1, SHALL be ignored with no state change.
REQ-018 Signed ops SHALL latch operand magnitudes plus result-sign bits; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held unsigned.
REQ-019 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrementing the counter, and move to FIX when the counter reaches 1; CALC lasts exactly WIDTH cycles.
REQ-020 FIX SHALL apply sign correction, write hi/lo, return to IDLE and pulse done in the cycle after the FIX edge.
REQ-021 Latency: start accepted at edge E0, so hi/lo update at edge E(WIDTH+1); done=1 and busy=0 in the following cycle; a new start is accepted in that same cycle.
REQ-022 Multiply: {hi,lo} is the full 2*WIDTH-bit product; signed product is negated when the operand signs differ.
REQ-023 Divide: lo = quotient, truncated toward zero; hi = remainder with the sign of the dividend.
REQ-024 Signed -2^(WIDTH-1) / -1 SHALL yield lo=-2^(WIDTH-1) and hi=0, with no trap.
REQ-025 Divide with b=0 SHALL still take full latency and yield lo=all-ones and hi=a (original value); dbz is set at FIX.
REQ-026 Any completed divide with b!=0 clears dbz; multiplies and MTHI/MTLO leave dbz unchanged.
REQ-027 abort=1 in CALC or FIX SHALL return to IDLE at the next edge with hi, lo and dbz unchanged and no done pulse.
REQ-028 abort=1 in IDLE has no effect; abort takes priority over a same-cycle FIX write.
REQ-029 Inputs a, b and op changing during CALC/FIX SHALL not affect the result.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, busy=0, done=0, dbz=0, hi=0, lo=0 and the counter to 0, including mid-operation.
REQ-031 After reset deasserts, the first edge with start=1 is accepted normally.

Verification (WIDTH=32)
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> at E33 hi=0xFFFFFFFF, lo=0xFFFFFFF1; done one cycle; busy high from E1 to E33.
REQ-033 DIVU a=100, b=7 -> lo=14, hi=2; then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, dbz=1; a following DIVU 9/3 -> lo=3, hi=0, dbz=0.
REQ-035 MTHI a=0xA5A5A5A5, then MTLO a=0x5A5A5A5A -> hi and lo take those values after one edge each, busy never high; a start with op=000 issued while busy is ignored.
REQ-036 Start MULTU 0xFFFFFFFF*0xFFFFFFFF, assert abort at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done; a rerun gives hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 Assert reset asynchronously mid-CALC -> busy, done, hi, lo and dbz are 0 before the next clk edge.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with sign fix-up and HI/LO writeback at the end.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [WIDTH-1:0]   d;
  logic [WIDTH:0]     p_hi;
  logic [WIDTH-1:0]   p_lo;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // op[0]=0 selects the signed variants; -2^(WIDTH-1) negates onto itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    mag_a     = (!op[0] && a[WIDTH-1]) ? -a : a;
    mag_b     = (!op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = p_hi + {1'b0, (p_lo[0] ? d : '0)};
    div_shift = {p_hi[WIDTH-1:0], p_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, d};
    prod      = {p_hi[WIDTH-1:0], p_lo};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -p_lo : p_lo;
    rem_fix   = neg_r ? -p_hi[WIDTH-1:0] : p_hi[WIDTH-1:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      d      <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              state  <= CALC;
              cnt    <= CW'(WIDTH);
              is_div <= op[1];
              // A zero divisor keeps the all-ones quotient un-negated.
              neg_q  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
              neg_r  <= !op[0] && a[WIDTH-1];
              b_zero <= (b == '0);
              d      <= op[1] ? mag_b : mag_a;
              p_hi   <= '0;
              p_lo   <= op[1] ? mag_a : mag_b;
            end else if (!op[1]) begin
              if (op[0]) lo <= a;
              else       hi <= a;
            end
          end
        end
        CALC: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
            if (is_div) begin
              if (!div_trial[WIDTH]) begin
                p_hi <= div_trial;
                p_lo <= {p_lo[WIDTH-2:0], 1'b1};
              end else begin
                p_hi <= div_shift;
                p_lo <= {p_lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              p_hi <= {1'b0, mul_sum[WIDTH:1]};
              p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!abort) begin
            done <= 1'b1;
            if (is_div) begin
              lo  <= quo_fix;
              hi  <= rem_fix;
              dbz <= b_zero;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
